// File: rtl/mem_arbiter2.sv
// ---------------------------------------------------------------------------
// mem_arbiter2
//
// Purpose:
//   Shares one single-port memory (combinational read, clocked write) between
//   two requesters, e.g. instruction fetch (port 0) and load/store (port 1).
//   Arbitration is round-robin. A port may lock ownership for an atomic
//   multi-access sequence. The lock is bounded: once MAX_LOCK consecutive
//   locked grants have gone to one port while the other port waits,
//   ownership is forcibly released.
//
// Ports:
//   clock            rising-edge clock
//   preset_L         asynchronous active-low reset
//   req0/req1        access request per port
//   we0/we1          1 = write, 0 = read
//   lock0/lock1      keep ownership after this grant
//   addr0/addr1      access address
//   wdata0/wdata1    write data
//   gnt0/gnt1        access performed this cycle (combinational)
//   rvalid0/rvalid1  registered one-cycle read-data-valid pulse
//   rdata0/rdata1    registered read data, held until the next read
//   mem_enable       memory enable
//   mem_we           memory write enable
//   mem_address      memory address
//   mem_data_in      memory write data
//   mem_data_out     memory combinational read data
// ---------------------------------------------------------------------------
module mem_arbiter2 #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic              clock,
    input  logic              preset_L,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    // One extra bit on the incremented count so the limit compare cannot wrap.
    localparam logic [CNT_W:0]   LOCK_LIMIT = (CNT_W + 1)'(MAX_LOCK);
    localparam logic [CNT_W-1:0] LOCK_SAT   = CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   lockCnt_q, lockCnt_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;

    logic               grant0, grant1;
    logic               ownerKept;
    logic [CNT_W:0]     lockCntInc;

    // Grant selection. An owner that still requests takes the memory
    // exclusively; an owner that dropped its request releases ownership in
    // the same cycle, so the cycle falls through to free round-robin.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == OWN0 && req0) begin
            grant0 = 1'b1;
        end else if (state_q == OWN1 && req1) begin
            grant1 = 1'b1;
        end else if (req0 && req1) begin
            if (last_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (req0) begin
            grant0 = 1'b1;
        end else if (req1) begin
            grant1 = 1'b1;
        end
    end

    // The locked-grant run only continues if the current owner is the one
    // granted again; a grant won through free arbitration starts a new run.
    // The stored count saturates at MAX_LOCK so a long uncontended lock can
    // never wrap and defeat the forced release once the other port shows up.
    always_comb begin
        ownerKept  = (state_q == OWN0 && grant0) || (state_q == OWN1 && grant1);
        lockCntInc = {1'b0, (ownerKept ? lockCnt_q : {CNT_W{1'b0}})} + {{CNT_W{1'b0}}, 1'b1};

        state_d   = FREE;
        lockCnt_d = '0;
        last_d    = last_q;

        if (grant0) begin
            last_d = 1'b0;
            if (lock0) begin
                if (lockCntInc >= LOCK_LIMIT && req1) begin
                    state_d   = FREE;
                    lockCnt_d = '0;
                end else begin
                    state_d   = OWN0;
                    lockCnt_d = (lockCntInc >= LOCK_LIMIT) ? LOCK_SAT : lockCntInc[CNT_W-1:0];
                end
            end
        end else if (grant1) begin
            last_d = 1'b1;
            if (lock1) begin
                if (lockCntInc >= LOCK_LIMIT && req0) begin
                    state_d   = FREE;
                    lockCnt_d = '0;
                end else begin
                    state_d   = OWN1;
                    lockCnt_d = (lockCntInc >= LOCK_LIMIT) ? LOCK_SAT : lockCntInc[CNT_W-1:0];
                end
            end
        end
    end

    // Memory side: the winner drives the bus; with no grant the address and
    // write data simply follow port 0 and the write enable stays low.
    always_comb begin
        mem_enable  = grant0 | grant1;
        mem_we      = grant1 ? we1 : (grant0 & we0);
        mem_address = grant1 ? addr1 : addr0;
        mem_data_in = grant1 ? wdata1 : wdata0;
    end

    // Read return path: capture the memory's combinational data at the edge
    // that ends a read grant; rdata holds until that port reads again.
    always_comb begin
        rvalid0_d = grant0 & ~we0;
        rvalid1_d = grant1 & ~we1;
        rdata0_d  = rvalid0_d ? mem_data_out : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_data_out : rdata1_q;
    end

    // State registers. last resets to 1 so port 0 wins the first conflict.
    always_ff @(posedge clock or negedge preset_L) begin
        if (!preset_L) begin
            state_q   <= FREE;
            last_q    <= 1'b1;
            lockCnt_q <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            lockCnt_q <= lockCnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign gnt0    = grant0;
    assign gnt1    = grant1;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter2
//
// Purpose:
//   Self-checking bench for mem_arbiter2. A behavioural memory is attached to
//   the arbiter's memory port, and a reference model tracks who owns the
//   memory, how long the current locked run is, who was served last and what
//   the memory should contain. Directed scenarios come first, followed by a
//   randomized phase where each requester holds its request until granted.
// ---------------------------------------------------------------------------
module tb_mem_arbiter2;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_LOCK = 8;

    logic              clock;
    logic              preset_L;
    logic              req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_enable, mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in, mem_data_out;

    logic [DATA_W-1:0] memArr [0:(1<<ADDR_W)-1];

    int checksTotal  = 0;
    int checksPassed = 0;
    int checksFailed = 0;

    // Reference model state.
    int                ownerM;
    int                runM;
    int                lastM;
    logic [DATA_W-1:0] expMem [int];
    logic              expRv0, expRv1;
    logic [DATA_W-1:0] expRd0, expRd1;
    logic              rd0Known, rd1Known;
    logic              sawGnt0, sawGnt1;

    mem_arbiter2 #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clock        (clock),
        .preset_L     (preset_L),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .lock0        (lock0),
        .lock1        (lock1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .mem_enable   (mem_enable),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural single-port memory: combinational read, clocked write.
    assign mem_data_out = memArr[mem_address];

    always @(posedge clock) begin
        if (mem_enable && mem_we) begin
            memArr[mem_address] <= mem_data_in;
        end
    end

    task automatic chkWord(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checksTotal++;
        assert (obs === exp) checksPassed++;
        else begin
            checksFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        checksTotal++;
        assert (obs === exp) checksPassed++;
        else begin
            checksFailed++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        ownerM   = -1;
        runM     = 0;
        lastM    = 1;
        expRv0   = 1'b0;
        expRv1   = 1'b0;
        expRd0   = '0;
        expRd1   = '0;
        rd0Known = 1'b1;
        rd1Known = 1'b1;
    endtask

    // Who the model says gets the memory this cycle (-1 = nobody).
    function automatic int pickWinner(input logic r0, input logic r1);
        if (ownerM == 0 && r0) return 0;
        if (ownerM == 1 && r1) return 1;
        if (r0 && r1) return (lastM == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    // One bus cycle: drive inputs after the falling edge, check the
    // combinational outputs, advance the model at the rising edge, then
    // check the registered read path just after it.
    task automatic applyStimulus(input logic r0, input logic r1, input logic w0, input logic w1,
                                 input logic k0, input logic k1,
                                 input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                 input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        int win;
        logic wwe, wlk, otherReq;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd, rd;
        logic rdKnown;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = k0; lock1 = k1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        #1;
        win      = pickWinner(r0, r1);
        wwe      = (win == 1) ? w1 : w0;
        wlk      = (win == 1) ? k1 : k0;
        wa       = (win == 1) ? a1 : a0;
        wd       = (win == 1) ? d1 : d0;
        otherReq = (win == 1) ? r0 : r1;
        sawGnt0  = gnt0;
        sawGnt1  = gnt1;
        chkBit("gnt0", gnt0, win == 0);
        chkBit("gnt1", gnt1, win == 1);
        chkBit("mem_enable", mem_enable, win >= 0);
        chkBit("mem_we", mem_we, (win >= 0) && wwe);
        chkWord("mem_address", {20'b0, mem_address}, {20'b0, wa});
        if (win >= 0 && wwe) chkWord("mem_data_in", mem_data_in, wd);
        @(posedge clock);
        expRv0 = 1'b0;
        expRv1 = 1'b0;
        if (win >= 0) begin
            if (wwe) begin
                expMem[int'(wa)] = wd;
            end else begin
                rdKnown = expMem.exists(int'(wa));
                rd      = rdKnown ? expMem[int'(wa)] : '0;
                if (win == 0) begin
                    expRv0 = 1'b1; expRd0 = rd; rd0Known = rdKnown;
                end else begin
                    expRv1 = 1'b1; expRd1 = rd; rd1Known = rdKnown;
                end
            end
            if (ownerM != win) runM = 0;
            lastM = win;
            if (wlk) begin
                runM++;
                if (runM >= MAX_LOCK && otherReq) begin
                    ownerM = -1;
                    runM   = 0;
                end else begin
                    ownerM = win;
                end
            end else begin
                ownerM = -1;
                runM   = 0;
            end
        end else begin
            ownerM = -1;
            runM   = 0;
        end
        #1;
        checkOutput();
        @(negedge clock);
    endtask

    task automatic checkOutput();
        chkBit("rvalid0", rvalid0, expRv0);
        chkBit("rvalid1", rvalid1, expRv1);
        if (rd0Known) chkWord("rdata0", rdata0, expRd0);
        if (rd1Known) chkWord("rdata1", rdata1, expRd1);
    endtask

    // Directed scenarios followed by a randomized phase.
    initial begin
        logic        act0, act1, pw0, pw1, pk0, pk1;
        logic [ADDR_W-1:0] pa0, pa1;
        logic [DATA_W-1:0] pd0, pd1;

        preset_L = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        modelReset();
        #2;
        chkBit("reset_rvalid0", rvalid0, 1'b0);
        chkBit("reset_rvalid1", rvalid1, 1'b0);
        chkWord("reset_rdata0", rdata0, '0);
        chkWord("reset_rdata1", rdata1, '0);
        chkBit("reset_mem_enable", mem_enable, 1'b0);
        @(negedge clock);
        preset_L = 1'b1;

        // Port 0 writes, port 1 reads it back one cycle later.
        applyStimulus(1, 0, 1, 0, 0, 0, 12'h010, 12'h000, 32'hDEADBEEF, 32'h0);
        chkBit("t1_gnt0", sawGnt0, 1'b1);
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000, 12'h010, 32'h0, 32'h0);
        chkBit("t1_gnt1", sawGnt1, 1'b1);
        chkWord("t1_rdata1", rdata1, 32'hDEADBEEF);

        // Continuous contention without locks alternates 0,1,0,1,...
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 12'h010, 12'h010, 32'h0, 32'h0);
            chkBit("t2_alt", sawGnt0, (i % 2) == 0);
        end

        // Port 1 read-modify-write under lock while port 0 keeps asking.
        applyStimulus(1, 0, 0, 0, 0, 0, 12'h010, 12'h000, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 0, 0, 1, 12'h020, 12'h020, 32'h0, 32'h0);
        chkBit("t3_rmw_rd", sawGnt1, 1'b1);
        applyStimulus(1, 1, 0, 1, 0, 0, 12'h020, 12'h020, 32'h0, 32'h12345678);
        chkBit("t3_rmw_wr", sawGnt1, 1'b1);
        applyStimulus(1, 0, 0, 0, 0, 0, 12'h020, 12'h000, 32'h0, 32'h0);
        chkBit("t3_gnt0", sawGnt0, 1'b1);
        chkWord("t3_rdata0", rdata0, 32'h12345678);

        // Port 0 holds its lock for 20 cycles against a waiting port 1.
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000, 12'h011, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 0, 0, 1, 0, ADDR_W'(i), 12'h012, 32'h0, 32'h0);
            if (i < 8) chkBit("t4_locked0", sawGnt0, 1'b1);
            if (i == 8 || i == 17) chkBit("t4_forced1", sawGnt1, 1'b1);
        end

        // Owner drops its request: the waiting port is served immediately.
        applyStimulus(0, 1, 0, 0, 0, 0, 12'h000, 12'h013, 32'h0, 32'h0);
        chkBit("t5_release", sawGnt1, 1'b1);

        // Reset in the middle of a locked sequence right after a read grant.
        applyStimulus(1, 0, 0, 0, 1, 0, 12'h020, 12'h000, 32'h0, 32'h0);
        #2;
        preset_L = 1'b0;
        #1;
        chkBit("t6_rvalid0", rvalid0, 1'b0);
        chkWord("t6_rdata0", rdata0, '0);
        req1 = 1'b1; lock0 = 1'b0;
        #1;
        chkBit("t6_inreset_gnt0", gnt0, 1'b1);
        @(negedge clock);
        preset_L = 1'b1;
        modelReset();
        applyStimulus(1, 1, 0, 0, 0, 0, 12'h010, 12'h020, 32'h0, 32'h0);
        chkBit("t6_conflict0", sawGnt0, 1'b1);

        // Randomized traffic: each port holds its request until granted.
        act0 = 0; act1 = 0;
        pw0 = 0; pw1 = 0; pk0 = 0; pk1 = 0;
        pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!act0 && ($urandom_range(0, 9) < 7)) begin
                act0 = 1;
                pw0  = $urandom_range(0, 2) == 0;
                pk0  = $urandom_range(0, 3) == 0;
                pa0  = ADDR_W'($urandom_range(0, 15));
                pd0  = $urandom;
            end
            if (!act1 && ($urandom_range(0, 9) < 7)) begin
                act1 = 1;
                pw1  = $urandom_range(0, 2) == 0;
                pk1  = $urandom_range(0, 3) == 0;
                pa1  = ADDR_W'($urandom_range(0, 15));
                pd1  = $urandom;
            end
            applyStimulus(act0, act1, pw0, pw1, pk0, pk1, pa0, pa1, pd0, pd1);
            if (sawGnt0) act0 = 0;
            if (sawGnt1) act1 = 0;
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
